// File: rtl/lpc_snoop_pkg.sv
// lpc_snoop_pkg: FSM states, LPC codes, record type and size decode shared by the LPC snooper.
// Define LPC_SNOOP_FWH_EN to also decode firmware-hub cycles.
package lpc_snoop_pkg;
`ifdef LPC_SNOOP_FWH_EN
   localparam bit FWH_EN = 1'b1;
`else
   localparam bit FWH_EN = 1'b0;
`endif
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_SIZE, S_ADDR, S_MSIZE, S_TAR_A, S_SYNC_R, S_SYNC_W, S_DATA, S_TAR_D, S_TAR_E, S_EMIT
   } state_t;
   typedef enum logic [1:0] {ST_OK, ST_SYNC_ERR, ST_TIMEOUT, ST_BAD_SYNC} status_t;
   localparam logic [3:0] START_LPC = 4'b0000, START_FWH_RD = 4'b1101, START_FWH_WR = 4'b1110, ABORT = 4'b1111;
   localparam logic [3:0] SYNC_READY = 4'b0000, SYNC_SHORT = 4'b0101, SYNC_LONG = 4'b0110, SYNC_ERR = 4'b1010;
   typedef struct packed {
      logic [3:0]  cyctype_dir;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  size;
      status_t     status;
      logic [7:0]  wait_cnt;
   } rec_t;
   // LPC size nibble uses 0011 for 4 bytes, FWH MSIZE uses 0010; 0 means invalid
   function automatic logic [2:0] size_dec(input logic [3:0] v, input logic fwh);
      return v == 4'd0 ? 3'd1 : v == 4'd1 ? 3'd2 : v == (fwh ? 4'd2 : 4'd3) ? 3'd4 : 3'd0;
   endfunction
endpackage

// File: rtl/lpc_snoop_decoder_if.sv
// lpc_snoop_decoder_if: LPC pin inputs plus the valid/ready record output of the snooper.
interface lpc_snoop_decoder_if;
   logic        lpc_frame;
   logic [3:0]  lpc_ad;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_cyctype_dir;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [2:0]  out_data_size;
   logic [1:0]  out_status;
   logic [7:0]  out_wait_cnt;
   modport master (
      output lpc_frame, lpc_ad, out_ready,
      input  out_valid, out_cyctype_dir, out_addr, out_data, out_data_size, out_status, out_wait_cnt
   );
   modport slave (
      input  lpc_frame, lpc_ad, out_ready,
      output out_valid, out_cyctype_dir, out_addr, out_data, out_data_size, out_status, out_wait_cnt
   );
endinterface

// File: rtl/lpc_rec_fifo.sv
// lpc_rec_fifo: first-word-fall-through record FIFO; a pop frees a slot for a same-cycle push.
module lpc_rec_fifo import lpc_snoop_pkg::*; #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  rec_t din,
   output rec_t dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(FIFO_DEPTH);
   rec_t mem [FIFO_DEPTH];
   logic [AW:0] wr, rd;
   logic do_push, do_pop;
   assign empty = wr == rd;
   assign full = wr == {~rd[AW], rd[AW-1:0]};
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = empty ? '0 : mem[rd[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr <= '0;
         rd <= '0;
      end else begin
         wr <= wr + {{AW{1'b0}}, do_push};
         rd <= rd + {{AW{1'b0}}, do_pop};
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/lpc_snoop_decoder.sv
// lpc_snoop_decoder: passive LPC snooper emitting one record per I/O or memory cycle into a FIFO.
// Firmware-hub decoding is enabled by defining LPC_SNOOP_FWH_EN.
module lpc_snoop_decoder import lpc_snoop_pkg::*; #(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_TIMEOUT   = 64,
   parameter int MEM_SIZE_FIELD = 1,
   parameter int CNT_W          = 16
) (
   input  logic             lpc_clock,
   input  logic             lpc_reset,
   lpc_snoop_decoder_if.slave bus,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] abort_cnt
);
   state_t st, nx;
   status_t status;
   logic [3:0] cnt, code, ct, lad, addr_lim, data_lim;
   logic [31:0] addr, data;
   logic [2:0] size;
   logic [7:0] wait_cnt;
   logic frame, abort, start_ok, fwh_start, is_wait, rdy, tmo, push, pop, full, empty;
   rec_t head;
   assign frame = bus.lpc_frame;
   assign lad = bus.lpc_ad;
   assign abort = !frame && lad == ABORT;
   assign start_ok = lad == START_LPC || (FWH_EN && (lad == START_FWH_RD || lad == START_FWH_WR));
   assign fwh_start = FWH_EN && code != START_LPC;
   assign is_wait = lad == SYNC_SHORT || lad == SYNC_LONG;
   assign rdy = lad == SYNC_READY || lad == SYNC_ERR;
   assign tmo = int'(wait_cnt) + 1 >= SYNC_TIMEOUT;
   // FWH: IDSEL arrives with the START-exit nibble, leaving 7 address nibbles
   assign addr_lim = ct[3] ? 4'd6 : ct[2] ? 4'd7 : 4'd3;
   assign data_lim = {size, 1'b0} - 4'd1;
   always_comb begin
      nx = st;
      if (abort) nx = S_IDLE;
      else if (!frame && lad == START_LPC && st != S_START) nx = S_START;
      else case (st)
         S_IDLE:             nx = (!frame && start_ok) ? S_START : S_IDLE;
         S_START:            nx = !frame ? (start_ok ? S_START : S_IDLE) :
                                  fwh_start ? S_ADDR :
                                  lad[3:2] == 2'b00 ? S_ADDR :
                                  lad[3:2] == 2'b01 ? (MEM_SIZE_FIELD != 0 ? S_SIZE : S_ADDR) : S_IDLE;
         S_SIZE:             nx = size_dec(lad, 1'b0) != 3'd0 ? S_ADDR : S_IDLE;
         S_ADDR:             nx = cnt != addr_lim ? S_ADDR : ct[3] ? S_MSIZE : ct[1] ? S_DATA : S_TAR_A;
         S_MSIZE:            nx = size_dec(lad, 1'b1) == 3'd0 ? S_IDLE : ct[1] ? S_DATA : S_TAR_A;
         S_TAR_A:            nx = cnt == 4'd1 ? S_SYNC_R : S_TAR_A;
         S_SYNC_R, S_SYNC_W: nx = is_wait ? (tmo ? S_EMIT : st) : !rdy ? S_EMIT :
                                  st == S_SYNC_R ? S_DATA : S_TAR_E;
         S_DATA:             nx = cnt == data_lim ? S_TAR_D : S_DATA;
         S_TAR_D:            nx = cnt != 4'd1 ? S_TAR_D : ct[1] ? S_SYNC_W : S_EMIT;
         S_TAR_E:            nx = cnt == 4'd1 ? S_EMIT : S_TAR_E;
         default:            nx = S_IDLE;
      endcase
   end
   always_ff @(posedge lpc_clock or negedge lpc_reset)
      if (!lpc_reset) begin
         st <= S_IDLE;
         cnt <= '0;
         code <= '0;
         ct <= '0;
         addr <= '0;
         data <= '0;
         size <= '0;
         status <= ST_OK;
         wait_cnt <= '0;
      end else begin
         st <= nx;
         cnt <= nx == st ? cnt + 4'd1 : '0;
         if (!frame) code <= lad;
         case (st)
            S_START: begin
               ct <= fwh_start ? code : lad;
               addr <= fwh_start ? {28'd0, lad} : '0;
               data <= '0;
               size <= 3'd1;
               status <= ST_OK;
               wait_cnt <= '0;
            end
            S_SIZE:  size <= size_dec(lad, 1'b0);
            S_MSIZE: size <= size_dec(lad, 1'b1);
            S_ADDR:  addr <= {addr[27:0], lad};
            S_DATA:  data[{cnt[2:0], 2'b00} +: 4] <= lad;
            S_SYNC_R, S_SYNC_W: begin
               if (is_wait) begin
                  wait_cnt <= &wait_cnt ? wait_cnt : wait_cnt + 8'd1;
                  if (tmo) status <= ST_TIMEOUT;
               end else if (lad == SYNC_ERR) status <= ST_SYNC_ERR;
               else if (lad != SYNC_READY) status <= ST_BAD_SYNC;
            end
            default: ;
         endcase
      end
   assign push = st == S_EMIT && !abort;
   assign pop = bus.out_valid && bus.out_ready;
   always_ff @(posedge lpc_clock or negedge lpc_reset)
      if (!lpc_reset) begin
         drop_cnt <= '0;
         abort_cnt <= '0;
      end else begin
         drop_cnt <= drop_cnt + CNT_W'(push && full && !pop && !(&drop_cnt));
         abort_cnt <= abort_cnt + CNT_W'(abort && st != S_IDLE && !(&abort_cnt));
      end
   lpc_rec_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(lpc_clock), .rst_n(lpc_reset), .push(push), .pop(pop),
      .din('{cyctype_dir: ct, addr: addr, data: data, size: size, status: status, wait_cnt: wait_cnt}),
      .dout(head), .full(full), .empty(empty)
   );
   assign bus.out_valid = !empty;
   assign bus.out_cyctype_dir = head.cyctype_dir;
   assign bus.out_addr = head.addr;
   assign bus.out_data = head.data;
   assign bus.out_data_size = head.size;
   assign bus.out_status = head.status;
   assign bus.out_wait_cnt = head.wait_cnt;
endmodule

// File: tb/tb_lpc_snoop_decoder.sv
// tb_lpc_snoop_decoder: scoreboard bench for the LPC snooper; expected records are queued as cycles are driven.
module tb_lpc_snoop_decoder;
   import lpc_snoop_pkg::*;
   localparam int DEPTH = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [15:0] drop_cnt, abort_cnt;
   int checks = 0, errors = 0, left;
   rec_t sb[$];
   lpc_snoop_decoder_if bus();
   lpc_snoop_decoder #(.FIFO_DEPTH(DEPTH), .SYNC_TIMEOUT(4), .MEM_SIZE_FIELD(1), .CNT_W(16)) dut (
      .lpc_clock(clk), .lpc_reset(rst_n), .bus(bus), .drop_cnt(drop_cnt), .abort_cnt(abort_cnt)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (rst_n && bus.out_valid && bus.out_ready) begin
      rec_t got, exp_r;
      got = '{bus.out_cyctype_dir, bus.out_addr, bus.out_data, bus.out_data_size,
              status_t'(bus.out_status), bus.out_wait_cnt};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL record: unexpected ct=%h addr=%h data=%h size=%0d st=%0d wait=%0d, expected none",
                  got.cyctype_dir, got.addr, got.data, got.size, got.status, got.wait_cnt);
      end else begin
         exp_r = sb.pop_front();
         if (got !== exp_r) begin
            errors++;
            $display("FAIL record: got ct=%h addr=%h data=%h size=%0d st=%0d wait=%0d, expected ct=%h addr=%h data=%h size=%0d st=%0d wait=%0d",
                     got.cyctype_dir, got.addr, got.data, got.size, got.status, got.wait_cnt,
                     exp_r.cyctype_dir, exp_r.addr, exp_r.data, exp_r.size, exp_r.status, exp_r.wait_cnt);
         end
      end
   end
   task automatic drive(input logic f, input logic [3:0] a);
      bus.lpc_frame = f;
      bus.lpc_ad = a;
      @(posedge clk);
      #1;
   endtask
   task automatic nib_msb(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) drive(1'b1, v[4*i +: 4]);
   endtask
   task automatic nib_lsb(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) drive(1'b1, v[4*i +: 4]);
   endtask
   task automatic wait_empty(output int n);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      #1 n = sb.size();
      sb.delete();
   endtask
   task automatic io_write(input logic [15:0] a, input logic [7:0] d, input bit keep);
      if (keep) sb.push_back('{4'h2, {16'h0, a}, {24'h0, d}, 3'd1, ST_OK, 8'd0});
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h2);
      nib_msb({16'h0, a}, 4);
      nib_lsb({24'h0, d}, 2);
      repeat (2) drive(1'b1, 4'hF);
      drive(1'b1, 4'h0);
      repeat (3) drive(1'b1, 4'hF);
   endtask
   task automatic test_reset;
      #1;
      checks += 4;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b, expected 0", bus.out_valid); end
      if (bus.out_addr !== 32'h0) begin errors++; $display("FAIL reset addr: got %h, expected 0", bus.out_addr); end
      if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset drop_cnt: got %0d, expected 0", drop_cnt); end
      if (abort_cnt !== 16'h0) begin errors++; $display("FAIL reset abort_cnt: got %0d, expected 0", abort_cnt); end
      rst_n = 1'b1;
      repeat (2) drive(1'b1, 4'hF);
      checks++;
      if (dut.st !== S_IDLE) begin errors++; $display("FAIL reset state: got %0d, expected IDLE", dut.st); end
   endtask
   task automatic test_io_write;
      io_write(16'h0080, 8'hA5, 1'b1);
      io_write(16'hBEEF, 8'h3C, 1'b1);
      wait_empty(left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL io_write drain: %0d outstanding, expected 0", left); end
   endtask
   task automatic test_mem_read;
      sb.push_back('{4'h4, 32'hFFFF_FFF0, 32'h8765_4321, 3'd4, ST_OK, 8'd3});
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h4);
      drive(1'b1, 4'h3);
      nib_msb(32'hFFFF_FFF0, 8);
      repeat (2) drive(1'b1, 4'hF);
      repeat (3) drive(1'b1, 4'h6);
      drive(1'b1, 4'h0);
      nib_lsb(32'h8765_4321, 8);
      repeat (3) drive(1'b1, 4'hF);
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h4);
      drive(1'b1, 4'h7);
      checks++;
      if (dut.st !== S_IDLE) begin errors++; $display("FAIL bad size state: got %0d, expected IDLE", dut.st); end
      nib_msb(32'h1234_5678, 8);
      wait_empty(left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL mem_read drain: %0d outstanding, expected 0", left); end
   endtask
   task automatic test_sync_status;
      sb.push_back('{4'h6, 32'h1000_0004, 32'h0000_BEEF, 3'd2, ST_SYNC_ERR, 8'd0});
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h6);
      drive(1'b1, 4'h1);
      nib_msb(32'h1000_0004, 8);
      nib_lsb(32'h0000_BEEF, 4);
      repeat (2) drive(1'b1, 4'hF);
      drive(1'b1, 4'hA);
      repeat (3) drive(1'b1, 4'hF);
      sb.push_back('{4'h0, 32'h0000_0070, 32'h0, 3'd1, ST_BAD_SYNC, 8'd0});
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h0);
      nib_msb(32'h70, 4);
      repeat (2) drive(1'b1, 4'hF);
      drive(1'b1, 4'h9);
      drive(1'b1, 4'hF);
      wait_empty(left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL sync_status drain: %0d outstanding, expected 0", left); end
   endtask
   task automatic test_abort;
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h2);
      drive(1'b1, 4'h0);
      drive(1'b0, 4'hF);
      drive(1'b1, 4'hF);
      checks++;
      if (abort_cnt !== 16'd1) begin errors++; $display("FAIL abort_cnt: got %0d, expected 1", abort_cnt); end
      io_write(16'h1234, 8'h5A, 1'b1);
      wait_empty(left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL abort drain: %0d outstanding, expected 0", left); end
   endtask
   task automatic test_timeout;
      sb.push_back('{4'h0, 32'h0000_0060, 32'h0, 3'd1, ST_TIMEOUT, 8'd4});
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h0);
      nib_msb(32'h60, 4);
      repeat (2) drive(1'b1, 4'hF);
      repeat (5) drive(1'b1, 4'h5);
      checks++;
      if (dut.st !== S_IDLE) begin errors++; $display("FAIL timeout state: got %0d, expected IDLE", dut.st); end
      drive(1'b1, 4'hF);
      wait_empty(left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL timeout drain: %0d outstanding, expected 0", left); end
   endtask
   task automatic test_back_to_back;
      bus.out_ready = 1'b0;
      for (int k = 0; k < DEPTH + 2; k++) io_write(16'h0100 + 16'(k), 8'(k * 17), k < DEPTH);
      checks += 3;
      if (drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt: got %0d, expected 2", drop_cnt); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full valid: got %b, expected 1", bus.out_valid); end
      if (bus.out_addr !== 32'h100) begin errors++; $display("FAIL held head: got %h, expected 00000100", bus.out_addr); end
      bus.out_ready = 1'b1;
      wait_empty(left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL back_to_back drain: %0d outstanding, expected 0", left); end
   endtask
   task automatic test_reset_mid;
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h2);
      nib_msb(32'h42, 4);
      drive(1'b1, 4'h5);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid reset valid: got %b, expected 0", bus.out_valid); end
      if (drop_cnt !== 16'h0) begin errors++; $display("FAIL mid reset drop_cnt: got %0d, expected 0", drop_cnt); end
      if (abort_cnt !== 16'h0) begin errors++; $display("FAIL mid reset abort_cnt: got %0d, expected 0", abort_cnt); end
      drive(1'b1, 4'hA);
      rst_n = 1'b1;
      repeat (2) drive(1'b1, 4'hF);
      drive(1'b1, 4'h0);
      repeat (8) drive(1'b1, 4'hF);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post reset valid: got %b, expected 0", bus.out_valid); end
   endtask
   task automatic test_fwh;
`ifdef LPC_SNOOP_FWH_EN
      sb.push_back('{4'hD, 32'h3FFF_FF00, 32'h0000_003C, 3'd1, ST_OK, 8'd0});
      drive(1'b0, 4'hD);
      drive(1'b1, 4'h3);
      nib_msb(32'hFFF_FF00, 7);
      drive(1'b1, 4'h0);
      repeat (2) drive(1'b1, 4'hF);
      drive(1'b1, 4'h0);
      nib_lsb(32'h3C, 2);
      repeat (3) drive(1'b1, 4'hF);
      wait_empty(left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL fwh drain: %0d outstanding, expected 0", left); end
`else
      drive(1'b0, 4'hD);
      checks++;
      if (dut.st !== S_IDLE) begin errors++; $display("FAIL fwh ignored state: got %0d, expected IDLE", dut.st); end
      drive(1'b1, 4'h3);
      nib_msb(32'hFFF_FF00, 7);
      repeat (8) drive(1'b1, 4'hF);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fwh ignored valid: got %b, expected 0", bus.out_valid); end
`endif
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.lpc_frame = 1'b1;
      bus.lpc_ad = 4'hF;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      test_reset;
      test_io_write;
      test_mem_read;
      test_sync_status;
      test_abort;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      test_fwh;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
